// File: rtl/noc_output_arbiter.sv
// Output-port arbiter for one mesh router port: round-robin choice among the
// input ports, gated by a downstream credit counter, with a registered flit output.
module noc_output_arbiter #(
   parameter int NUM_PORTS   = 5,
   parameter int total_width = 16,
   parameter int CREDITS     = 4,
   parameter int CRED_W      = 3,
   parameter int IDX_W       = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             i_req_valid,
   input  logic [NUM_PORTS*total_width-1:0] i_req_data,
   output logic [NUM_PORTS-1:0]             o_req_ready,
   output logic [total_width-1:0]           o_data,
   output logic                             o_data_valid,
   input  logic                             i_credit_return,
   output logic [CRED_W-1:0]                o_credits,
   output logic [IDX_W-1:0]                 o_grant_idx,
   output logic                             o_credit_err
);

   // Handshake: a flit moves when i_req_valid[k] & o_req_ready[k] are both high
   // in the same cycle. Ready is computed from valid, so requesters must never
   // make valid depend on ready.

   logic [CRED_W-1:0]      cnt;
   logic [CRED_W-1:0]      cnt_next;
   logic [IDX_W-1:0]       ptr;
   logic [NUM_PORTS-1:0]   grant;
   logic [IDX_W-1:0]       grant_idx;
   logic [total_width-1:0] grant_data;
   logic                   transfer;
   logic                   overflow;
   logic                   found;
   int                     idx;

   // Search starts one past the last winner and wraps, ending at the last winner.
   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      found     = 1'b0;
      idx       = 0;
      if (cnt != '0) begin
         for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(ptr) + off) % NUM_PORTS;
            if (!found && i_req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               grant_idx  = IDX_W'(idx);
            end
         end
      end
   end

   // AND-OR select keeps unknowns on losing ports away from the output flit.
   always_comb begin
      grant_data = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         grant_data = grant_data |
                      (i_req_data[k*total_width +: total_width] & {total_width{grant[k]}});
      end
   end

   assign transfer    = |grant;
   assign o_req_ready = grant;

   always_comb begin
      cnt_next = cnt;
      overflow = 1'b0;
      if (transfer && !i_credit_return) begin
         cnt_next = cnt - CRED_W'(1);
      end else if (!transfer && i_credit_return) begin
         if (cnt == CRED_W'(CREDITS)) overflow = 1'b1;
         else                         cnt_next = cnt + CRED_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= CRED_W'(CREDITS);
         ptr          <= IDX_W'(NUM_PORTS - 1);
         o_data       <= '0;
         o_data_valid <= 1'b0;
         o_credit_err <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         o_data_valid <= transfer;
         if (transfer) begin
            o_data <= grant_data;
            ptr    <= grant_idx;
         end
         if (overflow) o_credit_err <= 1'b1;
      end
   end

   assign o_credits   = cnt;
   assign o_grant_idx = ptr;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: directed scenarios plus random traffic, all
// checked against a round-robin / credit reference model and an expected-flit queue.
module tb_noc_output_arbiter;
   localparam int NP  = 5;
   localparam int W   = 16;
   localparam int CR  = 4;
   localparam int CW  = 3;
   localparam int IW  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     i_req_valid = '0;
   logic [NP*W-1:0]   i_req_data = '0;
   logic [NP-1:0]     o_req_ready;
   logic [W-1:0]      o_data;
   logic              o_data_valid;
   logic              i_credit_return = 1'b0;
   logic [CW-1:0]     o_credits;
   logic [IW-1:0]     o_grant_idx;
   logic              o_credit_err;

   noc_output_arbiter #(.NUM_PORTS(NP), .total_width(W), .CREDITS(CR),
                        .CRED_W(CW), .IDX_W(IW)) dut (
      .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
      .o_req_ready(o_req_ready), .o_data(o_data), .o_data_valid(o_data_valid),
      .i_credit_return(i_credit_return), .o_credits(o_credits),
      .o_grant_idx(o_grant_idx), .o_credit_err(o_credit_err));

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_cnt;
   int          m_ptr;
   bit          m_err;
   bit          exp_valid;
   logic [W-1:0] m_last;
   logic [W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt     = CR;
      m_ptr     = NP - 1;
      m_err     = 1'b0;
      exp_valid = 1'b0;
      m_last    = '0;
      exp_q.delete();
   endfunction

   // Winner = first valid port when visiting ptr+1, ptr+2, ... ptr (mod NP).
   function automatic int model_winner(input logic [NP-1:0] v);
      int order[$];
      if (m_cnt == 0) return -1;
      for (int k = 1; k <= NP; k++) order.push_back((m_ptr + k) % NP);
      foreach (order[i]) if (v[order[i]]) return order[i];
      return -1;
   endfunction

   // driver: apply one cycle of inputs, check combinational and registered results
   task automatic drive_cycle(input logic [NP-1:0] v, input logic [NP*W-1:0] d, input logic ret);
      int g;
      int nxt;
      logic [NP-1:0] exp_ready;
      logic [W-1:0]  exp_data;
      i_req_valid     = v;
      i_req_data      = d;
      i_credit_return = ret;
      #1;
      g = model_winner(v);
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("ready", o_req_ready, exp_ready);
      check("credits", o_credits, m_cnt);
      @(posedge clk);
      nxt = m_cnt - (g >= 0 ? 1 : 0) + (ret ? 1 : 0);
      if (nxt > CR) begin
         nxt   = CR;
         m_err = 1'b1;
      end
      m_cnt     = nxt;
      exp_valid = (g >= 0);
      if (g >= 0) begin
         exp_q.push_back(d[g*W +: W]);
         m_ptr = g;
      end
      #1;
      // scoreboard
      check("data_valid", o_data_valid, exp_valid);
      if (exp_valid) begin
         exp_data = exp_q.pop_front();
         check("data", o_data, exp_data);
         m_last = exp_data;
      end else begin
         check("data_hold", o_data, m_last);
      end
      check("grant_idx", o_grant_idx, m_ptr);
      check("credit_err", o_credit_err, m_err);
      check("credits_post", o_credits, m_cnt);
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      i_req_valid     = '0;
      i_credit_return = 1'b0;
      #1;
      model_reset();
      check("rst_valid", o_data_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_credits", o_credits, CR);
      check("rst_ptr", o_grant_idx, NP - 1);
      check("rst_err", o_credit_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [NP*W-1:0] fill(input logic [W-1:0] f0, input logic [W-1:0] f1,
                                          input logic [W-1:0] f2, input logic [W-1:0] f3,
                                          input logic [W-1:0] f4);
      return {f4, f3, f2, f1, f0};
   endfunction

   function automatic logic [NP*W-1:0] rand_data();
      logic [NP*W-1:0] d;
      for (int k = 0; k < NP; k++) d[k*W +: W] = W'($urandom_range(0, 65535));
      return d;
   endfunction

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      logic [NP*W-1:0] seq_data;
      seq_data = fill(16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004);
      @(posedge clk);
      #1;
      do_reset();

      // port 0 alone: four credits, four flits, then stall
      for (int i = 0; i < 4; i++) drive_cycle(5'b00001, fill(16'h6A14, 0, 0, 0, 0), 1'b0);
      drive_cycle(5'b00001, fill(16'h6A14, 0, 0, 0, 0), 1'b0);
      check("t1_stall_ready", o_req_ready, 0);
      check("t1_stall_credits", o_credits, 0);

      // all ports valid, credits recycled every cycle after the first
      do_reset();
      drive_cycle(5'b11111, seq_data, 1'b0);
      for (int i = 0; i < 11; i++) drive_cycle(5'b11111, seq_data, 1'b1);
      check("t2_ptr_after_12", o_grant_idx, 1);

      // drain to zero with port 0, then a single return lets port 2 through
      for (int i = 0; i < 3; i++) drive_cycle(5'b00001, seq_data, 1'b0);
      check("t3_zero", o_credits, 0);
      drive_cycle(5'b10100, seq_data, 1'b1);
      check("t3_one", o_credits, 1);
      drive_cycle(5'b10100, seq_data, 1'b0);
      check("t3_port2", o_grant_idx, 2);
      check("t3_back_zero", o_credits, 0);

      // overflow: transfer+return at full is harmless, bare return sets the flag
      do_reset();
      drive_cycle(5'b00001, seq_data, 1'b1);
      check("t4_no_err", o_credit_err, 0);
      drive_cycle(5'b00000, seq_data, 1'b1);
      check("t4_err", o_credit_err, 1);
      check("t4_sat", o_credits, CR);
      drive_cycle(5'b00000, seq_data, 1'b0);

      // reset while a flit is registered
      do_reset();
      drive_cycle(5'b00010, seq_data, 1'b0);
      drive_cycle(5'b00010, seq_data, 1'b0);
      check("t5_pre_valid", o_data_valid, 1);
      do_reset();
      drive_cycle(5'b01001, seq_data, 1'b0);
      check("t5_port0_wins", o_grant_idx, 0);

      // wrap-around from ptr 3
      do_reset();
      drive_cycle(5'b01000, seq_data, 1'b1);
      drive_cycle(5'b01010, seq_data, 1'b1);
      check("t6_first", o_grant_idx, 1);
      drive_cycle(5'b01010, seq_data, 1'b1);
      check("t6_second", o_grant_idx, 3);

      // random traffic with occasional resets
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         drive_cycle(NP'($urandom_range(0, 31)), rand_data(), $urandom_range(0, 99) < 55);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
